// File: rtl/ring_phase_decoder_pkg.sv
// Shared definitions for the ring-counter phase decoder: FSM state encodings
// and default sizing constants.
package ring_phase_decoder_pkg;

   typedef enum logic [1:0] {
      RPD_SYNC   = 2'b00,
      RPD_LOCKED = 2'b01,
      RPD_ERROR  = 2'b10
   } rpd_state_t;

   localparam int N_DEFAULT     = 4;
   localparam int REV_W_DEFAULT = 8;

endpackage

// File: rtl/ring_phase_decoder_if.sv
// Phase-bus interface between a ring counter (master) and the decoder (slave).
// The master drives en/phase/clr and observes the decoded outputs.
interface ring_phase_decoder_if
   import ring_phase_decoder_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int REV_W = REV_W_DEFAULT
);
   localparam int IW = $clog2(N);

   logic             en;
   logic [N-1:0]     phase;
   logic             clr;
   logic [IW-1:0]    idx;
   logic             valid;
   logic [REV_W-1:0] rev_count;
   logic             rev_pulse;
   logic             err;
   logic [N-1:0]     err_phase;

   modport master (
      output en, phase, clr,
      input  idx, valid, rev_count, rev_pulse, err, err_phase
   );

   modport slave (
      input  en, phase, clr,
      output idx, valid, rev_count, rev_pulse, err, err_phase
   );

endinterface

// File: rtl/ring_phase_decoder_onehot_to_bin.sv
// Combinational one-hot to binary converter with a one-hot validity flag.
// The index is only meaningful when o_onehot is high.
module onehot_to_bin #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_vec,
   output logic [IW-1:0] o_bin,
   output logic          o_onehot
);

   always_comb begin
      o_bin = '0;
      for (int i = 0; i < N; i++) begin
         if (i_vec[i]) o_bin = o_bin | IW'(i);
      end
   end

   // Non-zero with no second set bit: clearing the lowest set bit leaves zero.
   assign o_onehot = (i_vec != '0) && ((i_vec & (i_vec - 1'b1)) == '0);

endmodule

// File: rtl/ring_phase_decoder.sv
// Receive-side decoder for a ring-counter phase bus: locks onto the one-hot
// sequence, reports a binary index and revolution count, flags sticky errors.
module ring_phase_decoder
   import ring_phase_decoder_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int REV_W = REV_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ring_phase_decoder_if.slave  bus
);

   localparam int IW = $clog2(N);

   rpd_state_t       r_state, w_next;
   logic [N-1:0]     r_prev_phase_p0;
   logic             r_prev_en_p0;
   logic [IW-1:0]    r_idx, w_idx;
   logic             r_valid, w_valid;
   logic [REV_W-1:0] r_rev, w_rev;
   logic             r_pulse, w_pulse;
   logic             r_err, w_err;
   logic [N-1:0]     r_err_phase, w_err_phase;

   logic [IW-1:0]    w_bin;
   logic             w_onehot;
   logic [N-1:0]     w_exp;
   logic             w_match;
   logic             w_wrap;

   onehot_to_bin #(.N(N)) u_onehot_to_bin (
      .i_vec    (bus.phase),
      .o_bin    (w_bin),
      .o_onehot (w_onehot)
   );

   // The ring only advances on an edge where the enable was sampled high.
   assign w_exp   = r_prev_en_p0 ? {r_prev_phase_p0[N-2:0], r_prev_phase_p0[N-1]}
                                 : r_prev_phase_p0;
   assign w_match = (bus.phase == w_exp);
   assign w_wrap  = r_prev_en_p0 & r_prev_phase_p0[N-1] & bus.phase[0];

   always_comb begin
      w_next      = r_state;
      w_idx       = r_idx;
      w_valid     = r_valid;
      w_rev       = r_rev;
      w_pulse     = 1'b0;
      w_err       = r_err;
      w_err_phase = r_err_phase;
      if (bus.clr) begin
         w_next      = RPD_SYNC;
         w_valid     = 1'b0;
         w_rev       = '0;
         w_err       = 1'b0;
         w_err_phase = '0;
      end else begin
         unique case (r_state)
            RPD_SYNC: begin
               if (w_onehot) begin
                  w_next  = RPD_LOCKED;
                  w_idx   = w_bin;
                  w_valid = 1'b1;
               end
            end
            RPD_LOCKED: begin
               if (w_match) begin
                  w_idx = w_bin;
                  if (w_wrap) begin
                     w_rev   = r_rev + 1'b1;
                     w_pulse = 1'b1;
                  end
               end else begin
                  w_next      = RPD_ERROR;
                  w_valid     = 1'b0;
                  w_err       = 1'b1;
                  w_err_phase = bus.phase;
               end
            end
            RPD_ERROR: ;
            default: w_next = RPD_SYNC;
         endcase
      end
   end

   // Stage p0: history of the bus plus all decoded outputs, one edge after sampling.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= RPD_SYNC;
         r_prev_phase_p0 <= '0;
         r_prev_en_p0    <= 1'b0;
         r_idx           <= '0;
         r_valid         <= 1'b0;
         r_rev           <= '0;
         r_pulse         <= 1'b0;
         r_err           <= 1'b0;
         r_err_phase     <= '0;
      end else begin
         r_state         <= w_next;
         r_prev_phase_p0 <= bus.phase;
         r_prev_en_p0    <= bus.en;
         r_idx           <= w_idx;
         r_valid         <= w_valid;
         r_rev           <= w_rev;
         r_pulse         <= w_pulse;
         r_err           <= w_err;
         r_err_phase     <= w_err_phase;
      end
   end

   assign bus.idx       = r_idx;
   assign bus.valid     = r_valid;
   assign bus.rev_count = r_rev;
   assign bus.rev_pulse = r_pulse;
   assign bus.err       = r_err;
   assign bus.err_phase = r_err_phase;

endmodule

// File: tb/tb_ring_phase_decoder.sv
// Directed bench for ring_phase_decoder: two instances (REV_W 8 and 2) share
// the same stimulus; expected outputs are queued per step and checked after the edge.
module tb_ring_phase_decoder;

   typedef struct {
      logic [1:0] idx;
      logic       vld;
      int         rev;
      logic       pls;
      logic       err;
      logic [3:0] eph;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   exp_t q[$];

   ring_phase_decoder_if #(.N(4), .REV_W(8)) bus8 ();
   ring_phase_decoder_if #(.N(4), .REV_W(2)) bus2 ();

   ring_phase_decoder #(.N(4), .REV_W(8)) u_dut8 (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus8)
   );

   ring_phase_decoder #(.N(4), .REV_W(2)) u_dut2 (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, " idx8"},  32'(bus8.idx),       32'(e.idx));
      chk({tag, " vld8"},  32'(bus8.valid),     32'(e.vld));
      chk({tag, " rev8"},  32'(bus8.rev_count), 32'(e.rev & 255));
      chk({tag, " pls8"},  32'(bus8.rev_pulse), 32'(e.pls));
      chk({tag, " err8"},  32'(bus8.err),       32'(e.err));
      chk({tag, " eph8"},  32'(bus8.err_phase), 32'(e.eph));
      chk({tag, " idx2"},  32'(bus2.idx),       32'(e.idx));
      chk({tag, " vld2"},  32'(bus2.valid),     32'(e.vld));
      chk({tag, " rev2"},  32'(bus2.rev_count), 32'(e.rev & 3));
      chk({tag, " pls2"},  32'(bus2.rev_pulse), 32'(e.pls));
      chk({tag, " err2"},  32'(bus2.err),       32'(e.err));
      chk({tag, " eph2"},  32'(bus2.err_phase), 32'(e.eph));
   endtask

   task automatic drive(input logic e, input logic [3:0] ph, input logic c);
      bus8.en = e;  bus8.phase = ph;  bus8.clr = c;
      bus2.en = e;  bus2.phase = ph;  bus2.clr = c;
   endtask

   // Drive one edge's inputs, queue the expected result, check it after the edge.
   task automatic step(input string tag, input logic e, input logic [3:0] ph, input logic c,
                       input logic [1:0] x_idx, input logic x_vld, input int x_rev,
                       input logic x_pls, input logic x_err, input logic [3:0] x_eph);
      exp_t ex;
      exp_t got;
      drive(e, ph, c);
      ex.idx = x_idx; ex.vld = x_vld; ex.rev = x_rev;
      ex.pls = x_pls; ex.err = x_err; ex.eph = x_eph;
      q.push_back(ex);
      @(posedge clk);
      #1;
      got = q.pop_front();
      chk_all(tag, got);
   endtask

   initial begin
      exp_t zero;
      n_cmp = 0;
      n_bad = 0;
      zero.idx = 2'd0; zero.vld = 1'b0; zero.rev = 0;
      zero.pls = 1'b0; zero.err = 1'b0; zero.eph = 4'b0000;

      rst_n = 1'b0;
      drive(1'b0, 4'b0000, 1'b0);
      #1;
      chk_all("reset", zero);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Start-up zeros keep SYNC, then lock and one full revolution
      step("zero0", 1, 4'b0000, 0, 2'd0, 0, 0, 0, 0, 4'b0000);
      step("zero1", 1, 4'b0000, 0, 2'd0, 0, 0, 0, 0, 4'b0000);
      step("zero2", 1, 4'b0000, 0, 2'd0, 0, 0, 0, 0, 4'b0000);
      step("lock",  1, 4'b0001, 0, 2'd0, 1, 0, 0, 0, 4'b0000);
      step("ph1",   1, 4'b0010, 0, 2'd1, 1, 0, 0, 0, 4'b0000);
      step("ph2",   1, 4'b0100, 0, 2'd2, 1, 0, 0, 0, 4'b0000);
      step("ph3",   1, 4'b1000, 0, 2'd3, 1, 0, 0, 0, 4'b0000);
      step("wrap",  1, 4'b0001, 0, 2'd0, 1, 1, 1, 0, 4'b0000);
      step("ph1b",  1, 4'b0010, 0, 2'd1, 1, 1, 0, 0, 4'b0000);

      // Held phase with en low is legal; a skip afterwards is an error
      step("ph2h",  0, 4'b0100, 0, 2'd2, 1, 1, 0, 0, 4'b0000);
      for (int i = 0; i < 4; i++)
         step("hold", 0, 4'b0100, 0, 2'd2, 1, 1, 0, 0, 4'b0000);
      step("hold_en", 1, 4'b0100, 0, 2'd2, 1, 1, 0, 0, 4'b0000);
      step("skip",  1, 4'b0001, 0, 2'd2, 0, 1, 0, 1, 4'b0001);
      step("sticky", 1, 4'b0010, 0, 2'd2, 0, 1, 0, 1, 4'b0001);
      step("clr1",  0, 4'b0000, 1, 2'd2, 0, 0, 0, 0, 4'b0000);

      // Multi-hot error, clr-less hold, clear and relock
      step("relock", 1, 4'b0001, 0, 2'd0, 1, 0, 0, 0, 4'b0000);
      step("ph1c",  1, 4'b0010, 0, 2'd1, 1, 0, 0, 0, 4'b0000);
      step("multi", 1, 4'b0110, 0, 2'd1, 0, 0, 0, 1, 4'b0110);
      for (int i = 0; i < 4; i++)
         step("errhold", 0, 4'b0110, 0, 2'd1, 0, 0, 0, 1, 4'b0110);
      step("clr2",  0, 4'b0000, 1, 2'd1, 0, 0, 0, 0, 4'b0000);
      step("sync_mh", 1, 4'b0011, 0, 2'd1, 0, 0, 0, 0, 4'b0000);
      step("lock2", 1, 4'b0100, 0, 2'd2, 1, 0, 0, 0, 4'b0000);
      step("ph3c",  1, 4'b1000, 0, 2'd3, 1, 0, 0, 0, 4'b0000);

      // Illegal phase together with clr: clear wins, no error
      step("ill_clr", 1, 4'b0011, 1, 2'd3, 0, 0, 0, 0, 4'b0000);
      step("lock3", 1, 4'b0001, 0, 2'd0, 1, 0, 0, 0, 4'b0000);

      // Five revolutions; the REV_W=2 instance wraps 1,2,3,0,1
      for (int r = 1; r <= 5; r++) begin
         for (int k = 1; k <= 3; k++)
            step("rev_step", 1, 4'(1 << k), 0, 2'(k), 1, r - 1, 0, 0, 4'b0000);
         step("rev_wrap", 1, 4'b0001, 0, 2'd0, 1, r, 1, 0, 4'b0000);
      end
      step("post_wrap", 1, 4'b0010, 0, 2'd1, 1, 5, 0, 0, 4'b0000);

      // Asynchronous reset between edges clears outputs without a clock
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", zero);
      @(posedge clk);
      #1;
      chk_all("rst_held", zero);
      rst_n = 1'b1;
      step("rst_lock", 1, 4'b0100, 0, 2'd2, 1, 0, 0, 0, 4'b0000);
      step("rst_ph3",  1, 4'b1000, 0, 2'd3, 1, 0, 0, 0, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
